uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_fifo.sv | 39 +++
 rtl/uart_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and sizing constants for the UART receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FIFO_DEPTH-entry byte FIFO; a push while full is accepted only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_pop = pop_i & valid_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign valid_o = count != '0;
    assign full_o = count == (AW+1)'(FIFO_DEPTH);
    assign data_o = mem[rd_ptr];
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mem <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with sticky frame/overrun flags and a receive buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO buffer; otherwise a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rxd_i,
    input  logic       rx_rd_i,
    input  logic       err_clr_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o,
    output logic       rx_busy_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    state_t state, state_n;
    logic [1:0] sync;
    logic rx, rx_prev;
    logic [W-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, shreg_n;
    logic push, pop, full, set_fe, set_ov;
    assign rx = sync[1];
    assign rx_busy_o = state != IDLE;
    assign pop = rx_rd_i & rx_valid_o;
    assign set_ov = push & full & ~pop;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync <= 2'b11;
            rx_prev <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
        end else begin
            sync <= {sync[0], rxd_i};
            rx_prev <= rx;
            state <= state_n;
            cnt <= cnt_n;
            bit_cnt <= bit_n;
            shreg <= shreg_n;
        end
    end
    // Counter restarts at every sample point, so it never exceeds LAST.
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        bit_n = bit_cnt;
        shreg_n = shreg;
        push = 1'b0;
        set_fe = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (rx_prev && !rx) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n = '0;
                state_n = rx ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                shreg_n = {rx, shreg[7:1]};
                bit_n = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_n = '0;
                state_n = IDLE;
                push = rx;
                set_fe = !rx;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_frame_err_o <= 1'b0;
            rx_overrun_o <= 1'b0;
        end else begin
            rx_frame_err_o <= set_fe | (rx_frame_err_o & ~err_clr_i);
            rx_overrun_o <= set_ov | (rx_overrun_o & ~err_clr_i);
        end
    end
`ifdef UART_RX_FIFO_EN
    uart_rx_fifo u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (shreg),
        .data_o  (rx_data_o),
        .valid_o (rx_valid_o),
        .full_o  (full)
    );
`else
    assign full = rx_valid_o;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_data_o <= '0;
            rx_valid_o <= 1'b0;
        end else if (push && (!full || pop)) begin
            rx_data_o <= shreg;
            rx_valid_o <= 1'b1;
        end else if (pop) begin
            rx_valid_o <= 1'b0;
        end
    end
`endif
endmodule
